// File: rtl/q4_enc_pkg.sv
// Shared types, constants and word-formation helpers for the Q4 stimulus encoder.
package q4_enc_pkg;

    localparam int unsigned WORD_W = 8;
    localparam int unsigned LFSR_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [LFSR_W-1:0] LFSR_SEED          = 8'h01;
    localparam logic [LFSR_W-1:0] LFSR_TAPS          = 8'hB8;  // bits 7,5,4,3
    localparam logic [3:0]        MID_DEFAULT_NIBBLE = 4'b0001;

    typedef enum logic [1:0] {
        MODE_LOW  = 2'b00,
        MODE_MID  = 2'b01,
        MODE_HIGH = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_e;

    // An all-zero fill yields the fixed-filler words (MID nibble falls back to the default).
    function automatic logic [WORD_W-1:0] form_word(mode_e mode, logic [1:0] data,
                                                    logic [LFSR_W-1:0] fill);
        logic [3:0]        nib;
        logic [WORD_W-1:0] w;
        nib = fill[3:0];
        if (nib == 4'h0)
            nib = MID_DEFAULT_NIBBLE;
        else if (nib == 4'hF)
            nib = 4'hE;
        case (mode)
            MODE_LOW:  w = {4'h0, fill[5:4], data};
            MODE_MID:  w = {nib, fill[7], data[0], fill[5:4]};
            MODE_HIGH: w = {4'hF, data[0], fill[6:4]};
            default:   w = '0;
        endcase
        return w;
    endfunction

    function automatic logic [WORD_W-1:0] form_expect(mode_e mode, logic [1:0] data);
        logic [WORD_W-1:0] e;
        if (mode == MODE_LOW)
            e = {6'b0, data};
        else
            e = {7'b0, data[0]};
        return e;
    endfunction

endpackage

// File: rtl/q4_enc_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that advances only on step.
module q4_enc_lfsr
    import q4_enc_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              step,
    output logic [LFSR_W-1:0] value
);

    always_ff @(posedge clk or posedge clear) begin
        if (clear)
            value <= LFSR_SEED;
        else if (step)
            value <= {value[LFSR_W-2:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/q4_stim_encoder.sv
// Turns selector-path requests into 8-bit selector input words plus predicted outputs.
// Q4_ENC_LFSR_FILL_EN: when defined, filler bits are sourced from q4_enc_lfsr; otherwise zero.
module q4_stim_encoder
    import q4_enc_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_mode,
    input  logic [1:0]        req_data,
    input  logic [CNT_W-1:0]  req_count,
    output logic              enc_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] enc_word,
    output logic [WORD_W-1:0] enc_expect,
    output logic              cmd_err
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d, ld_mode;
    logic [1:0]         data_q, data_d, ld_data;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               valid_d, err_d, load;
    logic [WORD_W-1:0]  word_d, expect_d;
    logic [LFSR_W-1:0]  fill;

`ifdef Q4_ENC_LFSR_FILL_EN
    q4_enc_lfsr u_lfsr (
        .clk   (clk),
        .clear (clear),
        .step  (load),
        .value (fill)
    );
`else
    assign fill = '0;
`endif

    assign req_ready = (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_LOW;
            data_q      <= '0;
            remaining_q <= '0;
            enc_valid   <= 1'b0;
            enc_word    <= '0;
            enc_expect  <= '0;
            cmd_err     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            data_q      <= data_d;
            remaining_q <= remaining_d;
            enc_valid   <= valid_d;
            enc_word    <= word_d;
            enc_expect  <= expect_d;
            cmd_err     <= err_d;
        end
    end

    // Next-state and datapath; a word is loaded from the request on accept, else from the latch.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        data_d      = data_q;
        remaining_d = remaining_q;
        valid_d     = enc_valid;
        word_d      = enc_word;
        expect_d    = enc_expect;
        err_d       = 1'b0;
        load        = 1'b0;
        ld_mode     = mode_q;
        ld_data     = data_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (mode_e'(req_mode) == MODE_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        load        = 1'b1;
                        ld_mode     = mode_e'(req_mode);
                        ld_data     = req_data;
                        mode_d      = mode_e'(req_mode);
                        data_d      = req_data;
                        remaining_d = req_count;
                        valid_d     = 1'b1;
                        state_d     = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (enc_valid && out_ready) begin
                    if (remaining_q != '0) begin
                        load        = 1'b1;
                        remaining_d = remaining_q - CNT_W'(1);
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase

        if (load) begin
            word_d   = form_word(ld_mode, ld_data, fill);
            expect_d = form_expect(ld_mode, ld_data);
        end
    end

endmodule
